// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latency defaults and
// the pending-result type.
package md_pkg;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMthi  = 3'd5,
    MdMtlo  = 3'd6
  } md_op_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

  // Upper half goes to HI, lower half to LO on completion.
  typedef logic [63:0] md_pending_t;

endpackage

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider: quotient truncates toward zero and the
// remainder takes the sign of the dividend. A zero divisor yields zeros.
module md_divider
  import md_pkg::*;
(
  input  logic        is_signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, uq, ur;

  always_comb begin
    neg_a = is_signed_i & dividend_i[31];
    neg_b = is_signed_i & divisor_i[31];
    mag_a = neg_a ? (32'd0 - dividend_i) : dividend_i;
    mag_b = neg_b ? (32'd0 - divisor_i) : divisor_i;
    // Keep the operator X-free on divide-by-zero; the result is discarded anyway.
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq    = (mag_b == 32'd0) ? 32'd0 : (mag_a / div_b);
    ur    = (mag_b == 32'd0) ? 32'd0 : (mag_a % div_b);
    quot_o = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem_o  = neg_a ? (32'd0 - ur) : ur;
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding HI/LO. Results are computed at accept time and
// committed after a fixed busy latency; md_out reads only committed state.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MultCycles = MultCyclesDef,
  parameter int unsigned DivCycles  = DivCyclesDef
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [2:0]  md_op_i,
  input  logic        start_i,
  input  logic        cancel_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        rd_sel_i,
  output logic        busy_o,
  output logic [31:0] md_out_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned MaxCycles = (MultCycles > DivCycles) ? MultCycles : DivCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  md_pending_t   pend_q, pend_d;
  logic          dz_q, dz_d;

  md_op_e        op;
  logic          busy, accept, mul_signed;
  logic [63:0]   mul_a, mul_b, product;
  logic [31:0]   quot, rem;

  md_divider u_div (
    .is_signed_i (op == MdDiv),
    .dividend_i  (src_a_i),
    .divisor_i   (src_b_i),
    .quot_o      (quot),
    .rem_o       (rem)
  );

  always_comb begin
    op     = md_op_e'(md_op_i);
    busy   = (cnt_q != '0);
    accept = start_i && !cancel_i && !busy;
    // Sign-extending both operands lets one 64-bit multiplier serve mult and multu.
    mul_signed = (op == MdMult);
    mul_a   = {{32{mul_signed & src_a_i[31]}}, src_a_i};
    mul_b   = {{32{mul_signed & src_b_i[31]}}, src_b_i};
    product = mul_a * mul_b;
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    dz_d   = dz_q;
    if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if ((cnt_q == CntW'(1)) && !dz_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (accept) begin
      case (op)
        MdMult, MdMultu: begin
          pend_d = product;
          cnt_d  = CntW'(MultCycles);
          dz_d   = 1'b0;
        end
        MdDiv, MdDivu: begin
          pend_d = {rem, quot};
          cnt_d  = CntW'(DivCycles);
          dz_d   = (src_b_i == 32'd0);
        end
        MdMthi:  hi_d = src_a_i;
        MdMtlo:  lo_d = src_a_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      dz_q   <= dz_d;
    end
  end

  assign busy_o   = busy;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign md_out_o = rd_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed plus randomized bench for md_unit against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  localparam int MultLat = 5;
  localparam int DivLat  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic        start, cancel, rd_sel;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] md_out, hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .md_op_i  (md_op),
    .start_i  (start),
    .cancel_i (cancel),
    .src_a_i  (src_a),
    .src_b_i  (src_b),
    .rd_sel_i (rd_sel),
    .busy_o   (busy),
    .md_out_o (md_out),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
    rd_sel = 1'b0;
    #1 chk({tag, "_out_lo"}, md_out, m_lo);
    rd_sel = 1'b1;
    #1 chk({tag, "_out_hi"}, md_out, m_hi);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition of each op.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rhi, output logic [31:0] rlo, output int cyc);
    longint p, q, r;
    rhi = m_hi;
    rlo = m_lo;
    cyc = 0;
    case (op)
      MdMult, MdMultu: begin
        if (op == MdMult) p = longint'($signed(a)) * longint'($signed(b));
        else              p = longint'(a) * longint'(b);
        rhi = p[63:32];
        rlo = p[31:0];
        cyc = MultLat;
      end
      MdDiv, MdDivu: begin
        cyc = DivLat;
        if (b != 0) begin
          if (op == MdDiv) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
          end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
          end
          rhi = r[31:0];
          rlo = q[31:0];
        end
      end
      MdMthi: rhi = a;
      MdMtlo: rlo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit cxl, input string tag);
    logic [31:0] rhi, rlo;
    int cyc;
    ref_op(op, a, b, rhi, rlo, cyc);
    if (cxl) begin
      rhi = m_hi;
      rlo = m_lo;
      cyc = 0;
    end
    @(negedge clk);
    md_op = op; src_a = a; src_b = b; start = 1'b1; cancel = cxl;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    for (int k = 0; k < cyc; k++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_lo_hold"}, lo, m_lo);
      @(negedge clk);
    end
    m_hi = rhi;
    m_lo = rlo;
    chk({tag, "_idle"}, busy, 0);
    check_regs(tag);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          rc;

    reset = 1'b1; start = 1'b1; cancel = 1'b0; md_op = MdMult; rd_sel = 1'b0;
    src_a = 32'd7; src_b = 32'd9;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    check_regs("rst");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_rel_busy", busy, 0);

    run_op(MdMtlo, 32'h12345678, 32'h0, 1'b0, "mtlo");
    run_op(MdMult, 32'hFFFFFFFE, 32'd3, 1'b0, "mult");
    run_op(MdMultu, 32'hFFFFFFFE, 32'd3, 1'b0, "multu");
    run_op(MdDiv, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
    run_op(MdDivu, 32'd7, 32'd2, 1'b0, "divu");
    run_op(MdDiv, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    run_op(MdMthi, 32'hAA, 32'h0, 1'b0, "mthi");
    run_op(MdMtlo, 32'hBB, 32'h0, 1'b0, "mtlo2");
    run_op(MdDiv, 32'd1234, 32'd0, 1'b0, "div0");
    run_op(MdNone, 32'd5, 32'd5, 1'b0, "none");
    run_op(MdMult, 32'd5, 32'd5, 1'b1, "cancel");
    repeat (3) begin
      @(negedge clk);
      chk("cancel_stay_idle", busy, 0);
    end

    // MULT in flight; a DIV start and a cancel during busy must both be ignored.
    @(negedge clk);
    md_op = MdMult; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < MultLat; k++) begin
      chk("ign_busy", busy, 1);
      md_op = (k == 1) ? MdDiv : MdNone;
      src_a = 32'd100; src_b = 32'd3;
      start = (k == 1);
      cancel = (k == 2);
      @(negedge clk);
    end
    start = 1'b0; cancel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd25;
    chk("ign_idle", busy, 0);
    check_regs("ign");
    repeat (DivLat + 2) @(negedge clk);
    chk("ign_late_busy", busy, 0);
    chk("ign_late_lo", lo, 32'd25);

    // Asynchronous reset three cycles into a divide.
    run_op(MdMthi, 32'h55, 32'h0, 1'b0, "pre_rst");
    @(negedge clk);
    md_op = MdDivu; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (DivLat + 2) @(negedge clk);
    chk("arst_late_busy", busy, 0);
    check_regs("arst_late");

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      rc = ($urandom_range(0, 7) == 0);
      run_op(rop, ra, rb, rc, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
